// File: rtl/uart_rx.sv
// uart_rx: bus-attached 8N1 UART receiver with a DEPTH-entry receive FIFO.
// Register map (addr[1:0]): 0 DATA (pop), 1 STATUS, 2 COUNT, 3 reads 0.
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing with a
// sticky parity_err flag in STATUS bit 4 (cleared by writing 1).
module uart_rx #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] addr,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rx,
  output logic       irq
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(DEPTH);
  localparam logic [CW-1:0] HALF_LD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ENT_ONE = (AW + 1)'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, frame_err_q;
  logic [7:0]    rd_data_q;
  logic          rd_valid_q, irq_q;
  logic          fall_s, tick_s, stop_tick_s, push_s, push_ok_s, pop_s;
  logic          full_s, not_empty_s, ovr_set_s, frame_set_s;
  logic [7:0]    clr_s, status_s;
  logic          unused_s;
`ifdef UART_RX_PARITY_EN
  logic          par_ok_q, parity_err_q, par_set_s;
`endif

  assign unused_s = ^{addr[4:2], wr_data};

  // Receive-side decode: edge detect, sample ticks, push and flag-set strobes.
  always_comb begin
    fall_s      = rx_prev_q & ~rx_sync_q;
    tick_s      = (cnt_q == '0);
    stop_tick_s = (state_q == S_STOP) && tick_s;
    frame_set_s = stop_tick_s & ~rx_sync_q;
`ifdef UART_RX_PARITY_EN
    push_s      = stop_tick_s & rx_sync_q & par_ok_q;
    par_set_s   = (state_q == S_PARITY) && tick_s && (rx_sync_q != ^shift_q);
`else
    push_s      = stop_tick_s & rx_sync_q;
`endif
    full_s      = (count_q == CNT_FULL);
    not_empty_s = (count_q != '0);
    pop_s       = rd_en && (addr[1:0] == 2'd0) && not_empty_s;
    // a pop in the same cycle frees a slot, so a push into a full FIFO succeeds
    push_ok_s   = push_s && (!full_s || pop_s);
    ovr_set_s   = push_s && full_s && !pop_s;
    if (wr_en && (addr[1:0] == 2'd1)) begin
      clr_s = wr_data;
    end else begin
      clr_s = 8'h00;
    end
`ifdef UART_RX_PARITY_EN
    status_s = {3'b000, parity_err_q, frame_err_q, overrun_q, full_s, not_empty_s};
`else
    status_s = {3'b000, 1'b0, frame_err_q, overrun_q, full_s, not_empty_s};
`endif
  end

  // Next FIFO occupancy from the push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + ENT_ONE;
      2'b01:   count_d = count_q - ENT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Two-flop synchronizer plus previous-value flop for falling-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Frame FSM: start-bit check at mid bit, then one sample every DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_ok_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fall_s) begin
            state_q <= S_START;
            cnt_q   <= HALF_LD;
          end
        end
        S_START: begin
          if (!tick_s) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (!rx_sync_q) begin
            state_q   <= S_DATA;
            cnt_q     <= FULL_LD;
            bit_cnt_q <= 3'd0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DATA: begin
          if (!tick_s) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            shift_q <= {rx_sync_q, shift_q[7:1]};
            cnt_q   <= FULL_LD;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (!tick_s) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            par_ok_q <= (rx_sync_q == ^shift_q);
            cnt_q    <= FULL_LD;
            state_q  <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (!tick_s) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset since COUNT gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wptr_q] <= shift_q;
    end
  end

  // FIFO pointers, occupancy and the irq output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (push_ok_s) wptr_q <= wptr_q + PTR_ONE;
      if (pop_s)     rptr_q <= rptr_q + PTR_ONE;
      count_q <= count_d;
      irq_q   <= (count_d != '0);
    end
  end

  // Sticky error flags; a set in the same cycle as a clear-write wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      overrun_q    <= ovr_set_s   | (overrun_q   & ~clr_s[2]);
      frame_err_q  <= frame_set_s | (frame_err_q & ~clr_s[3]);
`ifdef UART_RX_PARITY_EN
      parity_err_q <= par_set_s   | (parity_err_q & ~clr_s[4]);
`endif
    end
  end

  // Registered read port answering rd_en one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        case (addr[1:0])
          2'd0:    rd_data_q <= not_empty_s ? mem_q[rptr_q] : 8'h00;
          2'd1:    rd_data_q <= status_s;
          2'd2:    rd_data_q <= 8'(count_q);
          default: rd_data_q <= 8'h00;
        endcase
      end else begin
        rd_data_q <= rd_data_q;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV = 12, DEPTH = 8 with a byte scoreboard.
module tb_uart_rx;

  logic       clk, rst, rd_en, wr_en, rx, rd_valid, irq;
  logic [4:0] addr;
  logic [7:0] wr_data, rd_data;

  int         total = 0;
  int         bad = 0;
  logic [7:0] sb[$];
  logic [7:0] d;
  logic [7:0] expv;

  uart_rx #(.CLK_HZ(12000000), .BAUD(1000000), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_data(wr_data), .rx(rx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // all tasks start and end 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [7:0] v);
    addr = a; rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("rd_valid", {7'd0, rd_valid}, 8'h01);
    v = rd_data;
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [7:0] v);
    addr = a; wr_data = v; wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
    check("wr_no_valid", {7'd0, rd_valid}, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(12);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(12);
    end
    rx = stop;
    tick(12);
    rx = 1'b1;
    tick(4);
  endtask

  task automatic read_data_sb(input string tag);
    reg_read(5'd0, d);
    expv = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    check(tag, d, expv);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = 5'd0; wr_data = 8'h00;
    tick(3);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_rd_valid", {7'd0, rd_valid}, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    rst = 1'b0;
    tick(2);
    reg_read(5'd1, d); check("rst_status", d, 8'h00);
    reg_read(5'd2, d); check("rst_count", d, 8'h00);
    reg_read(5'd3, d); check("reg3", d, 8'h00);
    reg_read(5'd0, d); check("empty_data", d, 8'h00);

    // single byte
    send_byte(8'hA5, 1'b1); sb.push_back(8'hA5);
    check("single_irq", {7'd0, irq}, 8'h01);
    reg_read(5'd2, d); check("single_count1", d, 8'h01);
    read_data_sb("single_data");
    check("single_irq_clr", {7'd0, irq}, 8'h00);
    reg_read(5'd2, d); check("single_count0", d, 8'h00);
    reg_write(5'd0, 8'h55);
    reg_read(5'd2, d); check("data_write_ignored", d, 8'h00);

    // overrun
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), 1'b1);
      if (sb.size() < 8) sb.push_back(8'(i));
    end
    reg_read(5'd1, d); check("ovr_status", d, 8'h07);
    reg_read(5'd2, d); check("ovr_count", d, 8'h08);
    for (int i = 0; i < 8; i++) read_data_sb("ovr_data");
    reg_read(5'd1, d); check("ovr_status_drained", d, 8'h04);
    reg_write(5'd1, 8'h04);
    reg_read(5'd1, d); check("ovr_cleared", d, 8'h00);

    // frame error, then read and clear STATUS in the same cycle
    send_byte(8'h3C, 1'b0);
    reg_read(5'd2, d); check("frm_count", d, 8'h00);
    check("frm_irq", {7'd0, irq}, 8'h00);
    addr = 5'd1; wr_data = 8'h08; rd_en = 1'b1; wr_en = 1'b1;
    tick(1);
    rd_en = 1'b0; wr_en = 1'b0;
    check("frm_rdwr_valid", {7'd0, rd_valid}, 8'h01);
    check("frm_status", rd_data, 8'h08);
    reg_read(5'd1, d); check("frm_cleared", d, 8'h00);

    // glitch rejection
    rx = 1'b0; tick(3); rx = 1'b1; tick(30);
    reg_read(5'd1, d); check("glitch_status", d, 8'h00);
    reg_read(5'd2, d); check("glitch_count", d, 8'h00);
    send_byte(8'hC3, 1'b1); sb.push_back(8'hC3);
    read_data_sb("post_glitch_data");

    // simultaneous push and pop on a full FIFO
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(8'h10 + i), 1'b1); sb.push_back(8'(8'h10 + i));
    end
    reg_read(5'd2, d); check("full_count", d, 8'h08);
    fork
      send_byte(8'h18, 1'b1);
      begin
        tick(116);
        addr = 5'd0; rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("pp_valid", {7'd0, rd_valid}, 8'h01);
        expv = sb.pop_front();
        check("pp_data", rd_data, expv);
      end
    join
    sb.push_back(8'h18);
    reg_read(5'd2, d); check("pp_count", d, 8'h08);
    reg_read(5'd1, d); check("pp_status", d, 8'h03);
    for (int i = 0; i < 8; i++) read_data_sb("pp_drain");
    reg_read(5'd2, d); check("pp_count0", d, 8'h00);

    // reset during bit 4 of 0xFF
    rx = 1'b0; tick(12);
    rx = 1'b1; tick(48 + 6);
    rst = 1'b1; tick(2);
    rst = 1'b0; tick(40);
    sb.delete();
    reg_read(5'd1, d); check("mid_rst_status", d, 8'h00);
    send_byte(8'h5A, 1'b1); sb.push_back(8'h5A);
    reg_read(5'd1, d); check("mid_rst_status1", d, 8'h01);
    read_data_sb("mid_rst_data");
    reg_read(5'd2, d); check("mid_rst_count", d, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Bus-attached UART receiver peripheral with an 8N1 deserializer and a small receive FIFO. It sits on the CPU's peripheral bus as a sibling of the transmit UART and LED blocks. The top-level decoder drives it with `rd_en`/`wr_en` and a 5-bit register address, and merges its `rd_data`/`rd_valid` into the CPU read path. It is the consumer end of the serial line and the producer of received bytes for the CPU.

## Interface
- `CLK_HZ`, 12000000, system clock frequency in Hz.
- `BAUD`, 115200, line rate; the divider `DIV = CLK_HZ/BAUD` uses integer truncation and must be ≥ 4.
- `DEPTH`, 8, FIFO entries; must be a power of two, 2..64.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `addr`  in  5  register address; only `addr[1:0]` is decoded.
- `rd_en`  in  1  one-cycle read strobe.
- `rd_data`  out  8  read data; meaningful only while `rd_valid` is high.
- `rd_valid`  out  1  one-cycle pulse answering `rd_en`.
- `wr_en`  in  1  one-cycle write strobe.
- `wr_data`  in  8  write data.
- `rx`  in  1  serial input; asynchronous, idles high.
- `irq`  out  1  high while the FIFO is non-empty.

## Operation
Register map:
- **0 DATA.** A read pops the FIFO head. A read while the FIFO is empty returns 0x00 and changes nothing. Writes are ignored.
- **1 STATUS.** Bit 0 = not_empty, bit 1 = full, bit 2 = overrun (sticky), bit 3 = frame_err (sticky), bits 7:4 = 0. Writing a 1 to bit 2 or bit 3 clears that flag.
- **2 COUNT.** Number of entries held, 0..DEPTH.
- **3.** Reads 0x00. Writes are ignored.

Receiver:
- `rx` passes through a 2-flop synchronizer; both flops reset to 1.
- **IDLE → START** on a synchronized falling edge. The counter is loaded with `DIV/2 - 1`.
- **START.** When the counter expires, sample the line. If it is low, go to DATA; if it is high (a glitch), return to IDLE.
- **DATA.** Sample every DIV cycles. Shift in 8 bits, LSB first.
- **STOP.** Sample after DIV cycles. If high, push the byte. If low, drop the byte and set frame_err. In both cases return to IDLE.
- Push while full: drop the byte, set overrun, leave FIFO contents unchanged.
- Push and pop in the same cycle: both take effect and COUNT is unchanged. When the FIFO is full, the pop happens first, so the push succeeds.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. COUNT is log2(DEPTH)+1 bits.
- A flag set and a clear-write to the same flag in the same cycle: the set wins.
- `rd_en` and `wr_en` asserted together: the block must handle both; behaviour is the same as each strobe on its own.

## Timing
- **Reset values.** `rd_data` = 0, `rd_valid` = 0, `irq` = 0, FIFO empty, all flags 0, state IDLE.
- **Reset mid-frame.** A partially received byte is discarded. After reset, reception restarts only on a new falling edge.
- **Read latency.** `rd_valid` and `rd_data` are registered and appear exactly 1 cycle after `rd_en`. Reads are never stalled.
- **Register reads.** STATUS and COUNT reflect state before any pop in the same cycle. A pop is visible in STATUS/COUNT on the following cycle.
- **Write timing.** A write takes effect on the edge where `wr_en` is high. `rd_valid` stays 0 for writes.
- **Push timing.** A push occurs on the mid-stop-bit sample cycle. `irq` and not_empty rise 1 cycle later.
- **End-to-end latency.** From the first low `rx` cycle to the push: 2 + (DIV/2) + 9·DIV cycles, ±1.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame is 8E1; a PARITY state sits between DATA and STOP.
  - A parity mismatch drops the byte and sets sticky STATUS bit 4 (parity_err).
  - Writing a 1 to bit 4 clears it.
- Undefined:
  - The frame is 8N1.
  - STATUS bit 4 reads 0.
  - No PARITY state logic exists.

## Test plan
All scenarios use `CLK_HZ` = 12000000, `BAUD` = 1000000 (DIV = 12), `DEPTH` = 8.
- **Single byte.** Send 0xA5 8N1 → `irq` = 1, then a DATA read gives `rd_valid` one cycle later with 0xA5, then COUNT reads 0 and `irq` = 0.
- **Overrun.** Send 9 bytes 0x01..0x09 without reading → STATUS = 0x07. Eight DATA reads return 0x01..0x08. Write 0x04 to STATUS → STATUS = 0x00.
- **Frame error.** Send 0x3C with the stop bit low → FIFO stays empty and STATUS = 0x08.
- **Glitch rejection.** Drive a 3-cycle low pulse on `rx` → no push, no flags, state returns to IDLE.
- **Simultaneous push and pop.** Fill the FIFO to 8, then issue a DATA read on the exact push cycle → the read returns the oldest byte, COUNT stays 8, and no overrun is set.
- **Mid-frame reset.** Assert `rst` during bit 4 of 0xFF, release it, then send 0x5A → only 0x5A is read back, and STATUS = 0x01 before the read.
